// File: rtl/keynsham_bus_defs.sv
// Shared definitions for the Keynsham memory arbiter.
// Holds the arbiter state and grant encodings, the bus width constants
// and the packed request payload captured from each bus.
package keynsham_bus_defs;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BSEL_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // One memory transaction as presented to the slave
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BSEL_W-1:0] bytesel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
  } mem_req_t;

endpackage

// File: rtl/keynsham_req_latch.sv
// Request latch for one bus: a pend bit plus the captured payload.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   access    - single-cycle request pulse from the bus
//   ack       - completion for this bus (clears pend)
//   req       - payload sampled with access
//   pend      - request outstanding
//   req_q     - latched payload
module keynsham_req_latch
  import keynsham_bus_defs::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     access,
  input  logic     ack,
  input  mem_req_t req,
  output logic     pend,
  output mem_req_t req_q
);

  // A new pulse wins over the clearing ack so back-to-back requests land;
  // a pulse while already pending (and not completing) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      req_q <= '0;
    end else if (access && (!pend || ack)) begin
      pend  <= 1'b1;
      req_q <= req;
    end else if (ack) begin
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/keynsham_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory slave between the
// Keynsham instruction and data buses, with a stall watchdog.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   i_access/i_addr                - fetch request pulse and word address
//   i_data/i_ack/i_err             - fetch response (combinational with m_ack)
//   d_access/d_addr/d_bytesel/
//   d_wr_en/d_wr_val               - data request pulse and payload
//   d_data/d_ack/d_err             - data response (combinational with m_ack)
//   m_access/m_addr/m_bytesel/
//   m_wr_en/m_wr_val               - registered memory request
//   m_data/m_ack                   - memory response
module keynsham_mem_arbiter
  import keynsham_bus_defs::*;
#(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_access,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_access,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BSEL_W-1:0] d_bytesel,
  input  logic              d_wr_en,
  input  logic [DATA_W-1:0] d_wr_val,
  output logic [DATA_W-1:0] d_data,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_access,
  output logic [ADDR_W-1:0] m_addr,
  output logic [BSEL_W-1:0] m_bytesel,
  output logic              m_wr_en,
  output logic [DATA_W-1:0] m_wr_val,
  input  logic [DATA_W-1:0] m_data,
  input  logic              m_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic             start;
  logic             i_pend;
  logic             d_pend;
  mem_req_t         i_req;
  mem_req_t         d_req;
  mem_req_t         i_req_q;
  mem_req_t         d_req_q;
  mem_req_t         m_req_q;

  // Fetches are always full-word reads
  assign i_req = '{addr: i_addr, bytesel: {BSEL_W{1'b1}}, wr_en: 1'b0, wr_val: '0};
  assign d_req = '{addr: d_addr, bytesel: d_bytesel, wr_en: d_wr_en, wr_val: d_wr_val};

  keynsham_req_latch u_i_latch (
    .clk    (clk),
    .rst    (rst),
    .access (i_access),
    .ack    (i_ack),
    .req    (i_req),
    .pend   (i_pend),
    .req_q  (i_req_q)
  );

  keynsham_req_latch u_d_latch (
    .clk    (clk),
    .rst    (rst),
    .access (d_access),
    .ack    (d_ack),
    .req    (d_req),
    .pend   (d_pend),
    .req_q  (d_req_q)
  );

  assign timeout_hit = (cnt == CNT_LAST);
  assign start       = (state == IDLE) && (state_nxt != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: round-robin on contention, leave BUSY on ack or watchdog
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_pend && d_pend)
          state_nxt = (last_grant == GRANT_D) ? I_BUSY : D_BUSY;
        else if (i_pend)
          state_nxt = I_BUSY;
        else if (d_pend)
          state_nxt = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (m_ack || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: route m_ack/m_data to the owner; a real ack beats the watchdog
  always_comb begin
    i_ack  = 1'b0;
    i_err  = 1'b0;
    i_data = '0;
    d_ack  = 1'b0;
    d_err  = 1'b0;
    d_data = '0;
    case (state)
      I_BUSY: begin
        if (m_ack) begin
          i_ack  = 1'b1;
          i_data = m_data;
        end else if (timeout_hit) begin
          i_ack = 1'b1;
          i_err = 1'b1;
        end
      end
      D_BUSY: begin
        if (m_ack) begin
          d_ack  = 1'b1;
          d_data = m_data;
        end else if (timeout_hit) begin
          d_ack = 1'b1;
          d_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Grant history, watchdog counter and the registered memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_D;
      cnt        <= '0;
      m_access   <= 1'b0;
      m_req_q    <= '0;
    end else begin
      m_access <= start;
      if (start) begin
        cnt <= '0;
        if (state_nxt == I_BUSY) begin
          last_grant <= GRANT_I;
          m_req_q    <= i_req_q;
        end else begin
          last_grant <= GRANT_D;
          m_req_q    <= d_req_q;
        end
      end else if ((state != IDLE) && !m_ack) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign m_addr    = m_req_q.addr;
  assign m_bytesel = m_req_q.bytesel;
  assign m_wr_en   = m_req_q.wr_en;
  assign m_wr_val  = m_req_q.wr_val;

endmodule
